// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  // Slice index width; never below one bit so a single-slice build still has a register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational CHUNK-bit unsigned compare with optional MSB inversion for signed top slices.
module slice_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_inv,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] mask;
  logic [CHUNK-1:0] aa;
  logic [CHUNK-1:0] bb;

  // Flipping the sign bit on both sides maps two's-complement order onto unsigned order.
  always_comb begin
    mask          = '0;
    mask[CHUNK-1] = msb_inv;
    aa            = a ^ mask;
    bb            = b ^ mask;
    gt            = (aa > bb);
    lt            = (aa < bb);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Cascadable magnitude comparator, one CHUNK slice per cycle, MSB slice first.
// Optional two's-complement compare of the top slice when SIGNED_CMP_EN is defined.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             i_aeqb,
  input  logic             i_agtb,
  input  logic             i_altb,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o_aeqb,
  output logic             o_agtb,
  output logic             o_altb
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IW         = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0 || NUM_CHUNKS < 1) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  result_t          casc_q;
  result_t          res;
  logic [IW-1:0]    idx;
  logic             smode_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic             msb_inv;
  logic             sl_gt;
  logic             sl_lt;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    msb_inv = smode_q && (idx == LAST_IDX);
  end

  slice_cmp #(.CHUNK(CHUNK)) u_slice_cmp (
    .a       (a_sl),
    .b       (b_sl),
    .msb_inv (msb_inv),
    .gt      (sl_gt),
    .lt      (sl_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      idx       <= LAST_IDX;
      a_q       <= '0;
      b_q       <= '0;
      casc_q    <= '0;
      smode_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            casc_q   <= '{eq: i_aeqb, gt: i_agtb, lt: i_altb};
`ifdef SIGNED_CMP_EN
            smode_q  <= signed_mode;
`else
            smode_q  <= 1'b0;
`endif
            idx      <= LAST_IDX;
            in_ready <= 1'b0;
            state    <= CMP;
          end
        end
        CMP: begin
          if (sl_gt || sl_lt) begin
            res       <= '{eq: 1'b0, gt: sl_gt, lt: sl_lt};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IW'(1);
          end else begin
            res       <= casc_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_aeqb = res.eq;
  assign o_agtb = res.gt;
  assign o_altb = res.lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=32, CHUNK=8); signed cases need SIGNED_CMP_EN.
module tb_seq_magnitude_comparator;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        i_aeqb = 1'b0;
  logic        i_agtb = 1'b0;
  logic        i_altb = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        o_aeqb;
  logic        o_agtb;
  logic        o_altb;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .i_aeqb      (i_aeqb),
    .i_agtb      (i_agtb),
    .i_altb      (i_altb),
`ifdef SIGNED_CMP_EN
    .signed_mode (signed_mode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_aeqb      (o_aeqb),
    .o_agtb      (o_agtb),
    .o_altb      (o_altb)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter and accept timestamp, taken at the active edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc;
  end

  // Monitor: pops one expectation on each new result presentation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("o_aeqb", int'(o_aeqb), int'(e.eq));
        chk("o_agtb", int'(o_agtb), int'(e.gt));
        chk("o_altb", int'(o_altb), int'(e.lt));
        chk("latency", cyc - acc_cyc, e.lat);
      end
    end
    ov_prev = out_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb,
                       input logic ceq, input logic cgt, input logic clt,
                       input logic sm, input logic push,
                       input logic eeq, input logic egt, input logic elt, input int lat);
    exp_t e;
    wait_ready();
    a = ta; b = tb;
    i_aeqb = ceq; i_agtb = cgt; i_altb = clt;
    signed_mode = sm;
    in_valid = 1'b1;
    if (push) begin
      e.eq = eeq; e.gt = egt; e.lt = elt; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_o_star", int'({o_aeqb, o_agtb, o_altb}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB slice decides immediately.
    issue(32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    issue(32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    // Full equality falls through to cascade inputs.
    issue(32'h1234_5678, 32'h1234_5678, 1, 0, 0, 0, 1, 1, 0, 0, 4);
    issue(32'h1234_5678, 32'h1234_5678, 0, 0, 1, 0, 1, 0, 0, 1, 4);
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 0, 0, 1, 1, 1, 0, 4);
    // Difference only in the lowest slice, then in the second slice.
    issue(32'h1234_5600, 32'h1234_56FF, 0, 0, 0, 0, 1, 0, 0, 1, 4);
    issue(32'h1235_0000, 32'h1234_FFFF, 0, 0, 0, 0, 1, 0, 1, 0, 2);
    issue(32'hAB00_0001, 32'hAB00_0100, 0, 1, 0, 0, 1, 0, 0, 1, 3);

    // Backpressure: result must hold while out_ready is low.
    wait_ready();
    out_ready = 1'b0;
    issue(32'h0000_0005, 32'h0000_0003, 0, 0, 1, 0, 1, 0, 1, 0, 4);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_o_star", int'({o_aeqb, o_agtb, o_altb}), 3'b010);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);

    // Reset in the middle of an equal-operand compare.
    issue(32'h5555_AAAA, 32'h5555_AAAA, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_o_star", int'({o_aeqb, o_agtb, o_altb}), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_result", int'(out_valid), 0);
    end
    issue(32'h0102_0304, 32'h0102_0305, 0, 0, 0, 0, 1, 0, 0, 1, 4);

`ifdef SIGNED_CMP_EN
    issue(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 1, 1, 0, 0, 1, 1);
`endif

    wait_ready();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
